usb_tx_pkt_retry_fifo: RTL and testbench

Parametrised synchronous TX packet FIFO between the USB endpoint data source and the USB device-controller TX path. It holds bytes until the host acknowledges the packet that carried them. A NAK or timeout causes a rewind to the packet start, so the same bytes are re-sent. It also reports free space and unread count, and latches the length of the next packet.

---
 rtl/usb_tx_pkt_retry_fifo_if.sv | 33 +++
 rtl/usb_tx_pkt_retry_fifo.sv | 92 +++++++++
 tb/tb_usb_tx_pkt_retry_fifo.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkt_retry_fifo_if.sv
// Bus bundle for the USB TX retry FIFO: write side, read side and
// packet-control strobes from the device controller.
interface usb_tx_pkt_retry_fifo_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 9
);
    logic             write;
    logic [DSIZE-1:0] iData;
    logic             full;
    logic [ASIZE:0]   free;
    logic             read;
    logic [DSIZE-1:0] oData;
    logic             empty;
    logic [ASIZE:0]   unread;
    logic             txact;
    logic             pktfin;
    logic             pktretry;
    logic [ASIZE:0]   pkt_len;
    logic             err_ovf;
    logic             err_udf;

    modport master (
        output write, iData, read, txact, pktfin, pktretry,
        input  full, free, oData, empty, unread, pkt_len,
        input  err_ovf, err_udf
    );

    modport slave (
        input  write, iData, read, txact, pktfin, pktretry,
        output full, free, oData, empty, unread, pkt_len,
        output err_ovf, err_udf
    );
endinterface

// File: rtl/usb_tx_pkt_retry_fifo.sv
// TX packet FIFO: bytes are freed only on host ACK; a NAK or
// timeout rewinds the read pointer to the start of the packet.
module usb_tx_pkt_retry_fifo #(
    parameter int DSIZE   = 8,
    parameter int ASIZE   = 9,
    parameter int MAX_PKT = 512
) (
    input logic CLK,
    input logic RST,
    usb_tx_pkt_retry_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] MAXP = (ASIZE+1)'(MAX_PKT);
    localparam logic [ASIZE:0] DEPTH_W = (ASIZE+1)'(DEPTH);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wp;
    logic [ASIZE:0]   rp;
    logic [ASIZE:0]   ack_rp;
    logic [ASIZE:0]   unread_w;
    logic [ASIZE:0]   used_w;
    logic [ASIZE:0]   pkt_len_q;
    logic             full_w;
    logic             empty_w;
    logic             do_wr;
    logic             do_rd;
    logic             retry;
    logic             txact_d0;
    logic             ovf_q;
    logic             udf_q;

    // Full is judged against ack_rp so unacknowledged data survives.
    assign full_w = (wp[ASIZE] != ack_rp[ASIZE]) &&
                    (wp[ASIZE-1:0] == ack_rp[ASIZE-1:0]);
    assign empty_w  = (wp == rp);
    assign unread_w = wp - rp;
    assign used_w   = wp - ack_rp;

    // An ACK in the same cycle overrides the rewind request.
    assign retry = bus.pktretry && !bus.pktfin;
    assign do_wr = bus.write && !full_w;
    assign do_rd = bus.read && !empty_w && !retry;

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wp[ASIZE-1:0]] <= bus.iData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wp       <= '0;
            rp       <= '0;
            ack_rp   <= '0;
            txact_d0 <= 1'b0;
            pkt_len_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            txact_d0 <= bus.txact;
            if (do_wr) begin
                wp <= wp + 1'b1;
            end
            if (bus.write && full_w) begin
                ovf_q <= 1'b1;
            end
            if (bus.read && empty_w) begin
                udf_q <= 1'b1;
            end
            if (bus.pktfin) begin
                ack_rp <= rp;
            end
            if (retry) begin
                rp <= ack_rp;
            end else if (do_rd) begin
                rp <= rp + 1'b1;
            end
            if (bus.txact && !txact_d0) begin
                pkt_len_q <= (unread_w > MAXP) ? MAXP : unread_w;
            end
        end
    end

    assign bus.full    = full_w;
    assign bus.empty   = empty_w;
    assign bus.unread  = unread_w;
    assign bus.free    = DEPTH_W - used_w;
    assign bus.oData   = mem[rp[ASIZE-1:0]];
    assign bus.pkt_len = pkt_len_q;
    assign bus.err_ovf = ovf_q;
    assign bus.err_udf = udf_q;
endmodule

// File: tb/tb_usb_tx_pkt_retry_fifo.sv
// Bench for usb_tx_pkt_retry_fifo: directed packet scenarios plus a
// randomized stream, all checked against a queue-based model.
module tb_usb_tx_pkt_retry_fifo;
    localparam int DS    = 8;
    localparam int AS    = 4;
    localparam int MP    = 8;
    localparam int DEPTH = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    usb_tx_pkt_retry_fifo_if #(.DSIZE(DS), .ASIZE(AS)) bus ();

    usb_tx_pkt_retry_fifo #(
        .DSIZE(DS), .ASIZE(AS), .MAX_PKT(MP)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: q holds every unacknowledged byte, roff is how many of
    // them have already been read out of the current packet.
    byte unsigned q[$];
    int  roff = 0;
    int  m_len = 0;
    bit  m_ovf = 1'b0;
    bit  m_udf = 1'b0;
    bit  m_tprev = 1'b0;
    int  ms, mu;
    bit  mwr, mrd;

    task automatic chk(input string name, input logic [31:0] act,
                       input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            q.delete();
            roff    = 0;
            m_len   = 0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_tprev = 1'b0;
        end else begin
            ms  = q.size();
            mu  = ms - roff;
            mwr = bus.write && (ms < DEPTH);
            mrd = bus.read && (mu > 0);
            if (bus.write && ms == DEPTH) m_ovf = 1'b1;
            if (bus.read && mu == 0) m_udf = 1'b1;
            if (bus.txact && !m_tprev) m_len = (mu < MP) ? mu : MP;
            m_tprev = bus.txact;
            if (bus.pktfin) begin
                for (int k = 0; k < roff; k++) void'(q.pop_front());
                roff = mrd ? 1 : 0;
            end else if (bus.pktretry) begin
                roff = 0;
            end else if (mrd) begin
                roff++;
            end
            if (mwr) q.push_back(bus.iData);
        end
    end

    int cs, cu;
    always @(negedge CLK) begin
        if (chk_en) begin
            cs = q.size();
            cu = cs - roff;
            chk("full",    bus.full,    int'(cs == DEPTH));
            chk("empty",   bus.empty,   int'(cu == 0));
            chk("free",    bus.free,    DEPTH - cs);
            chk("unread",  bus.unread,  cu);
            chk("pkt_len", bus.pkt_len, m_len);
            chk("err_ovf", bus.err_ovf, int'(m_ovf));
            chk("err_udf", bus.err_udf, int'(m_udf));
            if (cu > 0) chk("oData", bus.oData, int'(q[roff]));
        end
    end

    task automatic tick(input bit w, input byte unsigned d, input bit r,
                        input bit tx, input bit fin, input bit rt);
        bus.write    = w;
        bus.iData    = d;
        bus.read     = r;
        bus.txact    = tx;
        bus.pktfin   = fin;
        bus.pktretry = rt;
        @(negedge CLK);
        #1;
    endtask

    task automatic wr(input byte unsigned d);
        tick(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    bit rw, rr, rtx, rfin, rrt;

    initial begin
        bus.write = 0; bus.iData = 0; bus.read = 0;
        bus.txact = 0; bus.pktfin = 0; bus.pktretry = 0;
        @(negedge CLK);
        #1;
        idle();
        idle();
        chk_en = 1'b1;
        chk("rst_empty",  bus.empty,  1);
        chk("rst_full",   bus.full,   0);
        chk("rst_free",   bus.free,   16);
        chk("rst_unread", bus.unread, 0);
        chk("rst_len",    bus.pkt_len, 0);
        RST = 1'b0;

        for (int i = 0; i < 12; i++) wr(8'(8'h10 + i));
        chk("s1_empty",  bus.empty,  0);
        chk("s1_unread", bus.unread, 12);
        chk("s1_free",   bus.free,   4);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("s1_len", bus.pkt_len, 8);
        idle();
        for (int i = 0; i < 8; i++) begin
            chk("s1_data", bus.oData, 32'h10 + i);
            rd();
        end
        chk("s1_unread2", bus.unread, 4);
        chk("s1_free2",   bus.free,   4);

        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("s2_data0",  bus.oData,  8'h10);
        chk("s2_unread", bus.unread, 12);
        for (int i = 0; i < 8; i++) begin
            chk("s2_data", bus.oData, 32'h10 + i);
            rd();
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("s2_free", bus.free, 12);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("s2_noop_data",   bus.oData,  8'h18);
        chk("s2_noop_unread", bus.unread, 4);

        for (int i = 0; i < 4; i++) rd();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("s3_free0", bus.free, 16);
        for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
        chk("s3_full", bus.full, 1);
        chk("s3_free", bus.free, 0);
        for (int i = 0; i < 16; i++) begin
            chk("s3_data", bus.oData, 32'h20 + i);
            rd();
        end
        chk("s3_empty", bus.empty, 1);
        chk("s3_full2", bus.full,  1);
        chk("s3_ovf0",  bus.err_ovf, 0);
        wr(8'hEE);
        chk("s3_ovf",   bus.err_ovf, 1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("s3_full3", bus.full, 0);
        chk("s3_free3", bus.free, 16);

        for (int i = 0; i < 10; i++) wr(8'(8'h40 + i));
        for (int i = 0; i < 5; i++) rd();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("s4_free",   bus.free,   11);
        chk("s4_unread", bus.unread, 5);
        chk("s4_data",   bus.oData,  8'h45);
        rd();
        rd();
        chk("s4_data2", bus.oData, 8'h47);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("s4_rw_data",   bus.oData,  8'h45);
        chk("s4_rw_unread", bus.unread, 5);
        for (int i = 0; i < 5; i++) rd();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        chk("s6_udf0", bus.err_udf, 0);
        rd();
        chk("s6_udf",    bus.err_udf, 1);
        chk("s6_unread", bus.unread,  0);

        rtx = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rw   = ($urandom_range(0, 9) < 6);
            rr   = ($urandom_range(0, 9) < 6);
            rfin = ($urandom_range(0, 7) == 0);
            rrt  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) rtx = ~rtx;
            if (rfin && rrt) rr = 1'b0;
            tick(rw, 8'($urandom), rr, rtx, rfin, rrt);
        end

        RST = 1'b1;
        idle();
        RST = 1'b0;
        for (int i = 0; i < 6; i++) wr(8'(8'h60 + i));
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("s6_len", bus.pkt_len, 6);
        rd();
        RST = 1'b1;
        idle();
        RST = 1'b0;
        chk("s6_empty",  bus.empty,   1);
        chk("s6_free",   bus.free,    16);
        chk("s6_len0",   bus.pkt_len, 0);
        chk("s6_udf_rs", bus.err_udf, 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
